// File: rtl/intel_vvp_exposure_fusion_pkg.sv
// Shared types and width helpers for the exposure-fusion stream splitter.
package intel_vvp_exposure_fusion_pkg;

  typedef enum logic [1:0] {
    S_SYNC    = 2'd0,
    S_RUN     = 2'd1,
    S_RUN_1CH = 2'd2
  } state_e;

  // Per-channel beat width: each pixel is padded up to whole bytes.
  function automatic int calc_w(input int ncp, input int bps, input int pip);
    return ((ncp * bps + 7) / 8 * 8) * pip;
  endfunction

  function automatic int calc_u(input int w);
    return w / 8;
  endfunction

  // Bits needed to index v entries (0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/intel_vvp_exposure_fusion_split_fifo.sv
// Small register-based FIFO for one output channel; data read from rd_ptr_q.
module intel_vvp_exposure_fusion_split_fifo
  import intel_vvp_exposure_fusion_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             main_clock,
  input  logic             main_reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full
);

  localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign valid   = (count_q != '0);
  assign rdata   = mem_q[rd_ptr_q];
  // Guards keep the count in range even if the caller misbehaves.
  assign do_push = push && !full;
  assign do_pop  = pop && valid;

  // Next pointers, occupancy and storage contents.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; reset empties the FIFO.
  always_ff @(posedge main_clock) begin
    if (!main_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge main_clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/intel_vvp_exposure_fusion_split.sv
// Splits a two-channel video stream into two independent AXI4-S outputs,
// locking to SOF and dropping back to sync on a truncated line.
module intel_vvp_exposure_fusion_split
  import intel_vvp_exposure_fusion_pkg::*;
#(
  parameter  int NUMBER_OF_COLOR_PLANES = 2,
  parameter  int PIXELS_IN_PARALLEL     = 2,
  parameter  int BPS                    = 12,
  parameter  int OUT_FIFO_DEPTH         = 4,
  localparam int W = calc_w(NUMBER_OF_COLOR_PLANES, BPS, PIXELS_IN_PARALLEL),
  localparam int U = calc_u(W)
) (
  input  logic           main_clock,
  input  logic           main_reset_n,
  input  logic [2*W-1:0] axi4s_vid_in_tdata,
  input  logic [2*U-1:0] axi4s_vid_in_tuser,
  input  logic           axi4s_vid_in_tlast,
  input  logic           axi4s_vid_in_tvalid,
  output logic           axi4s_vid_in_tready,
  output logic [W-1:0]   axi4s_vid_out_0_tdata,
  output logic [U-1:0]   axi4s_vid_out_0_tuser,
  output logic           axi4s_vid_out_0_tlast,
  output logic           axi4s_vid_out_0_tvalid,
  input  logic           axi4s_vid_out_0_tready,
  output logic [W-1:0]   axi4s_vid_out_1_tdata,
  output logic [U-1:0]   axi4s_vid_out_1_tuser,
  output logic           axi4s_vid_out_1_tlast,
  output logic           axi4s_vid_out_1_tvalid,
  input  logic           axi4s_vid_out_1_tready,
  input  logic           ch1_enable
);

  localparam int EW = W + 2;  // {data, sof, eol}
  localparam int LW = 16;

  state_e          state_q, state_d;
  logic [LW-1:0]   line_q, line_d;
  logic            sync_lost_q, sync_lost_d;
  logic            in_ready, push0, push1, two_ch, sof;
  logic            full0, full1, valid0, valid1;
  logic [EW-1:0]   rdata0, rdata1;
  logic            unused_tuser;

  assign sof          = axi4s_vid_in_tuser[0];
  assign unused_tuser = ^axi4s_vid_in_tuser[2*U-1:1];

  // Next state, input ready and FIFO pushes.
  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    sync_lost_d = sync_lost_q;
    in_ready    = 1'b0;
    push0       = 1'b0;
    push1       = 1'b0;
    two_ch      = (state_q == S_RUN);
    case (state_q)
      S_SYNC: begin
        line_d = '0;
        if (axi4s_vid_in_tvalid && sof) begin
          // Hold the SOF on the bus; it is taken in the run state.
          state_d = ch1_enable ? S_RUN : S_RUN_1CH;
        end else begin
          in_ready = 1'b1;
        end
      end
      default: begin
        if (axi4s_vid_in_tvalid && sof && (line_q != '0)) begin
          // Truncated line: refuse the SOF and resynchronise on it.
          state_d     = S_SYNC;
          sync_lost_d = 1'b1;
          line_d      = '0;
        end else begin
          // A SOF beat already belongs to the mode chosen for its frame.
          if (axi4s_vid_in_tvalid && sof) two_ch = ch1_enable;
          in_ready = !full0 && (!two_ch || !full1);
          if (axi4s_vid_in_tvalid && in_ready) begin
            push0  = 1'b1;
            push1  = two_ch;
            line_d = axi4s_vid_in_tlast ? '0 : line_q + LW'(1);
            if (sof) state_d = ch1_enable ? S_RUN : S_RUN_1CH;
          end
        end
      end
    endcase
    if (!main_reset_n) begin
      in_ready = 1'b0;
      push0    = 1'b0;
      push1    = 1'b0;
    end
  end

  // State, line-beat counter and sticky sync-loss flag.
  always_ff @(posedge main_clock) begin
    if (!main_reset_n) begin
      state_q     <= S_SYNC;
      line_q      <= '0;
      sync_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      sync_lost_q <= sync_lost_d;
    end
  end

  assign axi4s_vid_in_tready = in_ready;

  intel_vvp_exposure_fusion_split_fifo #(.WIDTH(EW), .DEPTH(OUT_FIFO_DEPTH)) u_fifo0 (
    .main_clock   (main_clock),
    .main_reset_n (main_reset_n),
    .push         (push0),
    .wdata        ({axi4s_vid_in_tdata[W-1:0], sof, axi4s_vid_in_tlast}),
    .pop          (axi4s_vid_out_0_tvalid && axi4s_vid_out_0_tready),
    .rdata        (rdata0),
    .valid        (valid0),
    .full         (full0)
  );

  intel_vvp_exposure_fusion_split_fifo #(.WIDTH(EW), .DEPTH(OUT_FIFO_DEPTH)) u_fifo1 (
    .main_clock   (main_clock),
    .main_reset_n (main_reset_n),
    .push         (push1),
    .wdata        ({axi4s_vid_in_tdata[2*W-1:W], sof, axi4s_vid_in_tlast}),
    .pop          (axi4s_vid_out_1_tvalid && axi4s_vid_out_1_tready),
    .rdata        (rdata1),
    .valid        (valid1),
    .full         (full1)
  );

  // Unpack FIFO heads onto the output streams; nothing is valid in reset.
  always_comb begin
    axi4s_vid_out_0_tdata    = rdata0[EW-1:2];
    axi4s_vid_out_0_tuser    = '0;
    axi4s_vid_out_0_tuser[0] = rdata0[1];
    axi4s_vid_out_0_tlast    = rdata0[0];
    axi4s_vid_out_0_tvalid   = valid0 && main_reset_n;
    axi4s_vid_out_1_tdata    = rdata1[EW-1:2];
    axi4s_vid_out_1_tuser    = '0;
    axi4s_vid_out_1_tuser[0] = rdata1[1];
    axi4s_vid_out_1_tlast    = rdata1[0];
    axi4s_vid_out_1_tvalid   = valid1 && main_reset_n;
  end

endmodule

// File: tb/tb_intel_vvp_exposure_fusion_split.sv
// Directed bench for the exposure-fusion stream splitter.
module tb_intel_vvp_exposure_fusion_split;

  localparam int W = 48;
  localparam int U = 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [2*W-1:0] in_data;
  logic [2*U-1:0] in_user;
  logic           in_last, in_valid, in_ready;
  logic [W-1:0]   o0_data, o1_data;
  logic [U-1:0]   o0_user, o1_user;
  logic           o0_last, o1_last, o0_valid, o1_valid, o0_ready, o1_ready;
  logic           ch1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_acc;
  int first_acc, first_v0;
  bit last_acc, out1_seen, any_valid;
  logic [W+1:0] q0[$];
  logic [W+1:0] q1[$];

  always #5 clk = ~clk;

  intel_vvp_exposure_fusion_split dut (
    .main_clock             (clk),
    .main_reset_n           (rst_n),
    .axi4s_vid_in_tdata     (in_data),
    .axi4s_vid_in_tuser     (in_user),
    .axi4s_vid_in_tlast     (in_last),
    .axi4s_vid_in_tvalid    (in_valid),
    .axi4s_vid_in_tready    (in_ready),
    .axi4s_vid_out_0_tdata  (o0_data),
    .axi4s_vid_out_0_tuser  (o0_user),
    .axi4s_vid_out_0_tlast  (o0_last),
    .axi4s_vid_out_0_tvalid (o0_valid),
    .axi4s_vid_out_0_tready (o0_ready),
    .axi4s_vid_out_1_tdata  (o1_data),
    .axi4s_vid_out_1_tuser  (o1_user),
    .axi4s_vid_out_1_tlast  (o1_last),
    .axi4s_vid_out_1_tvalid (o1_valid),
    .axi4s_vid_out_1_tready (o1_ready),
    .ch1_enable             (ch1)
  );

  function automatic logic [W-1:0] lo(input int i);
    return {8'h0A, 8'h00, 32'(i)};
  endfunction

  function automatic logic [W-1:0] hi(input int i);
    return {8'h0B, 8'h00, 32'(i)};
  endfunction

  // Sample handshakes on the falling edge, then advance past the next rising edge.
  task automatic tick();
    @(negedge clk);
    last_acc = in_valid && in_ready;
    if (last_acc && first_acc < 0) first_acc = cyc;
    if (o0_valid && first_v0 < 0) first_v0 = cyc;
    if (o1_valid) out1_seen = 1'b1;
    if (o0_valid || o1_valid) any_valid = 1'b1;
    if (o0_valid && o0_ready) q0.push_back({o0_user[0], o0_last, o0_data});
    if (o1_valid && o1_ready) q1.push_back({o1_user[0], o1_last, o1_data});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_mon();
    q0.delete();
    q1.delete();
    out1_seen = 1'b0;
    any_valid = 1'b0;
    first_acc = -1;
    first_v0  = -1;
  endtask

  // Offer beats start..n-1 of a stream; n_acc ends as the index reached.
  task automatic offer(input int n, input int bpl, input bit sof_first,
                       input int base, input int start, input int budget);
    int j = start;
    int c = 0;
    while (j < n && c < budget) begin
      in_valid = 1'b1;
      in_data  = {hi(base + j), lo(base + j)};
      in_user  = '0;
      in_user[0] = sof_first && (j == 0);
      in_last  = ((j % bpl) == bpl - 1);
      tick();
      if (last_acc) j++;
      c++;
    end
    in_valid = 1'b0;
    n_acc = j;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_user = '0;
    in_user[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({in_ready, o0_valid, o1_valid} !== 3'b000)
        begin failures++; $display("FAIL reset_outputs cyc%0d got=%b want=000", i, {in_ready, o0_valid, o1_valid}); end
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_sync_ready got=%b want=1", in_ready); end
    checks++;
    if (dut.sync_lost_q !== 1'b0) begin failures++; $display("FAIL reset_sync_lost got=%b want=0", dut.sync_lost_q); end
  endtask

  task automatic test_frame();
    logic [W+1:0] e;
    ch1 = 1'b1; o0_ready = 1'b1; o1_ready = 1'b1;
    clear_mon();
    offer(8, 4, 1'b1, 0, 0, 40);
    repeat (4) tick();
    checks++;
    if (first_v0 - first_acc !== 1) begin failures++; $display("FAIL frame_latency got=%0d want=1", first_v0 - first_acc); end
    checks++;
    if (q0.size() !== 8 || q1.size() !== 8)
      begin failures++; $display("FAIL frame_count got=%0d/%0d want=8/8", q0.size(), q1.size()); end
    for (int i = 0; i < 8; i++) begin
      e = {i == 0, (i % 4) == 3, lo(i)};
      checks++;
      if (q0[i] !== e) begin failures++; $display("FAIL frame_out0 beat%0d got=%h want=%h", i, q0[i], e); end
      e = {i == 0, (i % 4) == 3, hi(i)};
      checks++;
      if (q1[i] !== e) begin failures++; $display("FAIL frame_out1 beat%0d got=%h want=%h", i, q1[i], e); end
    end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] e;
    ch1 = 1'b1; o0_ready = 1'b1; o1_ready = 1'b0;
    clear_mon();
    offer(12, 4, 1'b1, 100, 0, 10);
    checks++;
    if (n_acc !== 4) begin failures++; $display("FAIL bp_accepted got=%0d want=4", n_acc); end
    checks++;
    if (q0.size() !== 4) begin failures++; $display("FAIL bp_out0_count got=%0d want=4", q0.size()); end
    checks++;
    if ({in_ready, o1_valid, o0_valid} !== 3'b010)
      begin failures++; $display("FAIL bp_stalled got=%b want=010", {in_ready, o1_valid, o0_valid}); end
    o1_ready = 1'b1;
    offer(12, 4, 1'b1, 100, 4, 40);
    repeat (4) tick();
    checks++;
    if (q0.size() !== 12 || q1.size() !== 12)
      begin failures++; $display("FAIL bp_resume_count got=%0d/%0d want=12/12", q0.size(), q1.size()); end
    for (int i = 0; i < 12; i++) begin
      e = {i == 0, (i % 4) == 3, hi(100 + i)};
      checks++;
      if (q1[i] !== e) begin failures++; $display("FAIL bp_out1 beat%0d got=%h want=%h", i, q1[i], e); end
    end
  endtask

  task automatic test_single_channel();
    logic [W+1:0] e;
    ch1 = 1'b0; o0_ready = 1'b1; o1_ready = 1'b0;
    clear_mon();
    offer(8, 4, 1'b1, 200, 0, 20);
    repeat (4) tick();
    checks++;
    if (n_acc !== 8) begin failures++; $display("FAIL single_accepted got=%0d want=8", n_acc); end
    checks++;
    if (out1_seen !== 1'b0 || q1.size() !== 0)
      begin failures++; $display("FAIL single_out1_valid got=%b want=0", out1_seen); end
    checks++;
    if (q0.size() !== 8) begin failures++; $display("FAIL single_out0_count got=%0d want=8", q0.size()); end
    for (int i = 0; i < 8; i++) begin
      e = {i == 0, (i % 4) == 3, lo(200 + i)};
      checks++;
      if (q0[i] !== e) begin failures++; $display("FAIL single_out0 beat%0d got=%h want=%h", i, q0[i], e); end
    end
  endtask

  task automatic test_garbage();
    logic [W+1:0] e;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    ch1 = 1'b1; o0_ready = 1'b1; o1_ready = 1'b1;
    clear_mon();
    offer(5, 4, 1'b0, 250, 0, 10);
    repeat (3) tick();
    checks++;
    if (n_acc !== 5) begin failures++; $display("FAIL garbage_accepted got=%0d want=5", n_acc); end
    checks++;
    if (any_valid !== 1'b0 || q0.size() !== 0)
      begin failures++; $display("FAIL garbage_dropped got=%b/%0d want=0/0", any_valid, q0.size()); end
    offer(8, 4, 1'b1, 260, 0, 30);
    repeat (4) tick();
    e = {1'b1, 1'b0, lo(260)};
    checks++;
    if (q0.size() !== 8 || q0[0] !== e)
      begin failures++; $display("FAIL garbage_then_frame got=%0d/%h want=8/%h", q0.size(), q0[0], e); end
  endtask

  task automatic test_truncated();
    logic [W+1:0] e;
    ch1 = 1'b1; o0_ready = 1'b1; o1_ready = 1'b1;
    clear_mon();
    offer(2, 4, 1'b1, 300, 0, 10);
    offer(8, 4, 1'b1, 400, 0, 30);
    repeat (4) tick();
    checks++;
    if (dut.sync_lost_q !== 1'b1) begin failures++; $display("FAIL trunc_sync_lost got=%b want=1", dut.sync_lost_q); end
    checks++;
    if (q0.size() !== 10 || q1.size() !== 10)
      begin failures++; $display("FAIL trunc_count got=%0d/%0d want=10/10", q0.size(), q1.size()); end
    e = {1'b0, 1'b0, lo(301)};
    checks++;
    if (q0[1] !== e) begin failures++; $display("FAIL trunc_partial got=%h want=%h", q0[1], e); end
    for (int i = 0; i < 8; i++) begin
      e = {i == 0, (i % 4) == 3, lo(400 + i)};
      checks++;
      if (q0[2 + i] !== e) begin failures++; $display("FAIL trunc_new_frame beat%0d got=%h want=%h", i, q0[2 + i], e); end
    end
  endtask

  task automatic test_mid_reset();
    logic [W+1:0] e;
    ch1 = 1'b1; o0_ready = 1'b0; o1_ready = 1'b0;
    clear_mon();
    offer(8, 4, 1'b1, 500, 0, 8);
    checks++;
    if ({n_acc, o0_valid, o1_valid, in_ready} !== {32'd4, 3'b110})
      begin failures++; $display("FAIL midrst_full got=%0d/%b want=4/110", n_acc, {o0_valid, o1_valid, in_ready}); end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({o0_valid, o1_valid, in_ready} !== 3'b000)
      begin failures++; $display("FAIL midrst_in_reset got=%b want=000", {o0_valid, o1_valid, in_ready}); end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({o0_valid, o1_valid} !== 2'b00)
      begin failures++; $display("FAIL midrst_after got=%b want=00", {o0_valid, o1_valid}); end
    o0_ready = 1'b1; o1_ready = 1'b1;
    clear_mon();
    offer(8, 4, 1'b1, 600, 0, 30);
    repeat (4) tick();
    e = {1'b1, 1'b0, lo(600)};
    checks++;
    if (q0.size() !== 8 || q0[0] !== e)
      begin failures++; $display("FAIL midrst_out0 got=%0d/%h want=8/%h", q0.size(), q0[0], e); end
    e = {1'b1, 1'b0, hi(600)};
    checks++;
    if (q1.size() !== 8 || q1[0] !== e)
      begin failures++; $display("FAIL midrst_out1 got=%0d/%h want=8/%h", q1.size(), q1[0], e); end
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_user = '0; in_last = 1'b0; in_valid = 1'b0;
    o0_ready = 1'b1; o1_ready = 1'b1; ch1 = 1'b1;
    clear_mon();
    test_reset();
    test_frame();
    test_backpressure();
    test_single_channel();
    test_garbage();
    test_truncated();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
